// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch types and constants: FSM state encoding, PC step, instruction width.
package riscv_fetch_pkg;
  typedef enum logic [1:0] {FETCH, WAIT, DROP} fetch_state_t;
  localparam int PC_INC  = 4;
  localparam int INSTR_W = 32;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response bundle between fetch (master) and memory (slave).
interface fetch_pc_unit_if #(parameter int PC_W = 9);
  import riscv_fetch_pkg::*;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;

  modport master (output imem_req_valid, imem_addr,
                  input  imem_req_ready, imem_rsp_valid, imem_rsp_data);
  modport slave  (input  imem_req_valid, imem_addr,
                  output imem_req_ready, imem_rsp_valid, imem_rsp_data);
endinterface

// File: rtl/fetch_pc_unit_ibuf.sv
// One-entry IF/ID instruction buffer: capture from memory, consume by decode, kill on redirect.
module fetch_ibuf
  import riscv_fetch_pkg::*;
#(
  parameter int PC_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               capture,
  input  logic [INSTR_W-1:0] cap_instr,
  input  logic [PC_W-1:0]    cap_pc,
  input  logic               stall,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic               buf_free
);
  // Free when empty or when decode takes the entry at this edge.
  assign buf_free = !valid || !stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      instr <= cap_instr;
      pc    <= cap_pc;
    end else if (valid && !stall) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC owner: issues one request at a time, buffers one instruction, applies execute redirects.
module fetch_pc_unit
  import riscv_fetch_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PcSel,
  input  logic [31:0]        BrPC,
  input  logic               Stall,
  fetch_pc_unit_if.master    imem,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               Flush,
  output logic               misalign_err
);
  fetch_state_t    state;
  logic [PC_W-1:0] pc_q, req_pc_q, target;
  logic            buf_free, capture, accept;
  logic            unused_brpc;

  assign target      = {BrPC[PC_W-1:2], 2'b00};
  assign unused_brpc = ^BrPC[31:PC_W];
  assign Flush       = PcSel;

  assign imem.imem_req_valid = (state == FETCH) && buf_free && !PcSel;
  assign imem.imem_addr      = pc_q;
  assign accept              = imem.imem_req_valid && imem.imem_req_ready;
  assign capture             = (state == WAIT) && imem.imem_rsp_valid && !PcSel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= FETCH;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (PcSel && (BrPC[1:0] != 2'b00)) misalign_err <= 1'b1;
      case (state)
        FETCH: begin
          if (PcSel) begin
            pc_q <= target;
          end else if (accept) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + PC_W'(PC_INC);
            state    <= WAIT;
          end
        end
        WAIT: begin
          // A redirect without the response still owes us one return to drop.
          if (PcSel) begin
            pc_q  <= target;
            state <= imem.imem_rsp_valid ? FETCH : DROP;
          end else if (imem.imem_rsp_valid) begin
            state <= FETCH;
          end
        end
        DROP: begin
          if (PcSel) pc_q <= target;
          if (imem.imem_rsp_valid) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  fetch_ibuf #(.PC_W(PC_W)) u_ibuf (
    .clk      (clk),
    .reset    (reset),
    .flush    (PcSel),
    .capture  (capture),
    .cap_instr(imem.imem_rsp_data),
    .cap_pc   (req_pc_q),
    .stall    (Stall),
    .valid    (if_valid),
    .instr    (if_instr),
    .pc       (if_pc),
    .buf_free (buf_free)
  );
endmodule
